instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory's 30-bit word address combinationally from the PC.
- Captures the returned 32-bit instruction, plus PC and PC+4, into the IF/ID pipeline register for decode.
- Handles stall, flush and branch/jump redirect from decode, with MIPS single delay-slot semantics.

Parameters:
- RESET_PC, 32'h0040_0000, byte address loaded into the PC on reset (word 0x0010_0000 of the instruction memory).
- IMEM_LO_WORD, 30'h0010_0000, lowest valid instruction-memory word address (used only by the range check).
- IMEM_HI_WORD, 30'h0010_0090, highest valid instruction-memory word address, inclusive (used only by the range check).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and IF/ID (decode hazard)
- flush  in  1  squash the IF/ID contents next edge
- branch_taken  in  1  decode-resolved taken branch
- branch_target  in  32  branch byte target
- jump  in  1  decode J/JAL
- jump_target  in  26  instr_index field
- imem_addr  out  30  word address to the instruction memory, = pc[31:2]
- imem_data  in  32  instruction returned combinationally by the memory
- if_pc  out  32  PC of the instruction in IF/ID
- if_pc_plus4  out  32  if_pc + 4
- if_instr  out  32  instruction in IF/ID
- if_valid  out  1  IF/ID holds a real instruction
- fetch_fault  out  1  sticky out-of-range fetch flag (optional feature)

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC.
  - if_pc = 0, if_pc_plus4 = 0, if_instr = 32'h0000_0000 (NOP), if_valid = 0, fetch_fault = 0.
  - Outputs take these values immediately on reset assertion, not at the next edge.
  - The first rising edge after deassertion loads IF/ID from RESET_PC.
- Address path:
  - imem_addr = pc[31:2], combinational, zero cycles.
  - imem_data is sampled at the same edge that advances the PC. Fetch latency is 1 cycle from PC to IF/ID.
- next_pc, in priority order:
  1. jump: {pc[31:28], jump_target, 2'b00}. pc is the delay-slot PC.
  2. branch_taken: {branch_target[31:2], 2'b00}. Low bits are forced to zero.
  3. Otherwise: pc + 4, mod 2^32; wraps from 32'hFFFF_FFFC to 0 with no flag.
- Per rising edge, in priority order:
  1. flush = 1:
     - if_valid <= 0, if_instr <= 0; if_pc and if_pc_plus4 hold.
     - pc <= next_pc (redirect honoured) when stall = 0; pc holds when stall = 1.
     - Flush overrides stall for IF/ID.
  2. stall = 1, flush = 0:
     - pc and all IF/ID outputs hold.
     - branch_taken and jump are ignored; decode re-asserts them when the stall releases.
  3. Otherwise:
     - pc <= next_pc.
     - if_instr <= imem_data, if_pc <= pc, if_pc_plus4 <= pc + 4, if_valid <= 1.
- Delay slot: the instruction fetched in the cycle a redirect is asserted is the delay slot. It enters IF/ID with if_valid = 1 unless flush is also asserted.
- Simultaneous jump and branch_taken: jump wins.
- A redirect to the current pc is legal and re-fetches the same word.
- Reset asserted mid-stall or mid-redirect: reset wins immediately; pending redirect is discarded.

Optional Feature:
- Macro: FETCH_RANGE_CHECK_EN.
- Defined:
  - At any advancing edge (stall = 0) where pc[31:2] < IMEM_LO_WORD or > IMEM_HI_WORD, fetch_fault <= 1.
  - fetch_fault is sticky until reset. Fetch continues unchanged; the IF/ID contents are not altered.
- Undefined:
  - fetch_fault is tied to 0 and no comparator logic is synthesised.

Decomposition:
- Shared package: constant RESET_PC_DEFAULT; constant NOP_INSTR = 32'h0; field-width constants INSTR_INDEX_W = 26 and WORD_ADDR_W = 30; localparam PC_INC = 4.
- One natural sub-module, if_id_reg:
  - IF/ID pipeline register with stall/flush/load controls and async reset.
  - instr_fetch keeps the PC register, next-PC mux and range check.

Test Plan:
1. Reset, then 4 free-running cycles:
   - imem_addr steps 0x0010_0000, 0x0010_0001, 0x0010_0002, 0x0010_0003.
   - if_pc = 0x0040_0000, then 0x0040_0004, 0x0040_0008.
   - if_valid = 0 during reset, 1 from the first edge after deassertion.
2. Branch at pc = 0x0040_0008 with branch_taken = 1, branch_target = 0x0040_0023:
   - Next pc = 0x0040_0020 (low bits cleared).
   - The delay slot at 0x0040_0008 appears in IF/ID with if_valid = 1.
3. Jump and branch_taken together, pc = 0x0040_0010, jump_target = 26'h010_0004, branch_target = 0x0040_0100:
   - Next pc = 0x0040_0010 (jump wins).
4. Stall for 3 cycles with branch_taken = 1:
   - pc, imem_addr and IF/ID are frozen; the redirect is ignored.
   - On release, fetch resumes at pc + 4.
5. Flush with stall = 1:
   - if_valid = 0, if_instr = 0, pc holds.
   - Flush with stall = 0 and branch_taken = 1: pc = target and if_valid = 0.
6. Range check, with FETCH_RANGE_CHECK_EN defined:
   - Jump to pc = 0x0040_0244 sets fetch_fault = 1, which stays high until reset.
   - With the macro undefined, fetch_fault stays 0.
   - Async reset mid-cycle: outputs return to reset values before the next edge.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared constants, IF/ID payload type and jump-target helper for the fetch stage.
package instr_fetch_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned INSTR_INDEX_W = 26;
   localparam int unsigned WORD_ADDR_W   = 30;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_INC           = 32'd4;

   // Contents of the IF/ID pipeline register handed to decode.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

   // J/JAL target: region bits come from the delay-slot PC.
   function automatic logic [XLEN-1:0] jump_pc(input logic [XLEN-1:0]          pc,
                                               input logic [INSTR_INDEX_W-1:0] idx);
      return {pc[XLEN-1:XLEN-4], idx, 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush squashes the instruction, stall holds, otherwise loads.
module if_id_reg
   import instr_fetch_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   stall,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   // Flush keeps pc/pc_plus4 so decode still sees where the bubble came from.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
      end else if (flush) begin
         q.valid <= 1'b0;
         q.instr <= NOP_INSTR;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, next-PC mux with MIPS delay-slot redirect, IF/ID capture.
// Optional sticky out-of-range fetch flag built when FETCH_RANGE_CHECK_EN is defined.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0]        RESET_PC     = RESET_PC_DEFAULT,
   parameter logic [WORD_ADDR_W-1:0] IMEM_LO_WORD = 30'h0010_0000,
   parameter logic [WORD_ADDR_W-1:0] IMEM_HI_WORD = 30'h0010_0090
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     branch_taken,
   input  logic [XLEN-1:0]          branch_target,
   input  logic                     jump,
   input  logic [INSTR_INDEX_W-1:0] jump_target,
   output logic [WORD_ADDR_W-1:0]   imem_addr,
   input  logic [XLEN-1:0]          imem_data,
   output logic [XLEN-1:0]          if_pc,
   output logic [XLEN-1:0]          if_pc_plus4,
   output logic [XLEN-1:0]          if_instr,
   output logic                     if_valid,
   output logic                     fetch_fault
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4_c;
   logic [XLEN-1:0] next_pc_c;
   if_id_t          ifid_d;
   if_id_t          ifid_q;
   logic            unused_target_lsbs;

   assign pc_plus4_c = pc_q + PC_INC;

   // Jump beats branch; sequential fetch wraps silently at the top of memory.
   always_comb begin
      next_pc_c = pc_plus4_c;
      if (jump) begin
         next_pc_c = jump_pc(pc_q, jump_target);
      end else if (branch_taken) begin
         next_pc_c = {branch_target[XLEN-1:2], 2'b00};
      end
   end

   assign unused_target_lsbs = ^branch_target[1:0];

   // A stalled cycle drops any redirect; decode re-asserts it after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else if (!stall) begin
         pc_q <= next_pc_c;
      end
   end

   assign imem_addr = pc_q[XLEN-1:2];

   assign ifid_d = '{pc: pc_q, pc_plus4: pc_plus4_c, instr: imem_data, valid: 1'b1};

   if_id_reg u_if_id (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .flush (flush),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign if_pc       = ifid_q.pc;
   assign if_pc_plus4 = ifid_q.pc_plus4;
   assign if_instr    = ifid_q.instr;
   assign if_valid    = ifid_q.valid;

`ifdef FETCH_RANGE_CHECK_EN
   logic out_of_range_c;
   logic fault_q;

   assign out_of_range_c = (imem_addr < IMEM_LO_WORD) || (imem_addr > IMEM_HI_WORD);

   // Sticky until reset; fetch itself is not affected by the flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else if (!stall && out_of_range_c) begin
         fault_q <= 1'b1;
      end
   end

   assign fetch_fault = fault_q;
`else
   logic unused_range_cfg;

   assign unused_range_cfg = ^{IMEM_LO_WORD, IMEM_HI_WORD};
   assign fetch_fault      = 1'b0;
`endif

endmodule
